ddr_app_mem_model: RTL

Synthesisable, parametrised model of a DDR controller user (app) interface: it accepts app commands and write data, stores the data in an internal word array, and returns the stored data on reads after a fixed latency. Command and write-data ready can be throttled by an LFSR. It sits in place of the DDR IP under the AXI4-to-native bridge, so bridge and VDMA simulations and FPGA loop-back builds check real data, not just handshakes.

---
 rtl/ddr_model_pkg.sv | 16 +
 rtl/ddr_model_fifo.sv | 53 +++++
 rtl/ddr_app_mem_model.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ddr_model_pkg.sv
// ddr_model_pkg: shared definitions for the DDR app-interface memory model.
//   CMD_WR / CMD_RD : app_cmd encodings that the model acts on
//   wdf_entry_t     : {data, mask} write-data FIFO entry layout (default width)
package ddr_model_pkg;

   localparam logic [2:0] CMD_WR = 3'b000;
   localparam logic [2:0] CMD_RD = 3'b001;

   localparam int unsigned DDR_DATA_W = 256;

   typedef struct packed {
      logic [DDR_DATA_W-1:0]   data;
      logic [DDR_DATA_W/8-1:0] mask;
   } wdf_entry_t;

endpackage

// File: rtl/ddr_model_fifo.sv
// ddr_model_fifo: synchronous FIFO with show-ahead head output.
//   clock, rst_n : clock and asynchronous active-low reset (pointers only)
//   push, din    : write port; caller never pushes when full
//   pop, dout    : read port; dout is the current head, caller never pops when empty
//   full, empty  : occupancy flags from registered state
module ddr_model_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;

   // Pointer and occupancy tracking
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Storage is not reset
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/ddr_app_mem_model.sv
// ddr_app_mem_model: stand-in for the DDR IP app interface backed by a word array.
// Optional feature macro: DDR_MODEL_RAND_RDY_EN (LFSR throttle on app_rdy / app_wdf_rdy).
// Ports:
//   clock, rst_n                     : clock, asynchronous active-low reset
//   app_addr, app_cmd, app_en        : command in; app_rdy command ready
//   app_wdf_data/mask/wren/end       : write data in; app_wdf_rdy write-data ready
//   app_rd_data/_valid/_end          : read data out, RD_LATENCY cycles after issue
//   init_calib_complete              : high CALIB_CYCLES clocks after reset release
module ddr_app_mem_model
   import ddr_model_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 27,
   parameter int unsigned DATA_WIDTH   = 256,
   parameter int unsigned ADDR_LSB     = 3,
   parameter int unsigned MEM_AW       = 10,
   parameter int unsigned WQ_DEPTH     = 8,
   parameter int unsigned RQ_DEPTH     = 8,
   parameter int unsigned RD_LATENCY   = 16,
   parameter int unsigned CALIB_CYCLES = 1000,
   parameter int unsigned RDY_THRESH   = 128,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic                    clock,
   input  logic                    rst_n,
   input  logic [ADDR_WIDTH-1:0]   app_addr,
   input  logic [2:0]              app_cmd,
   input  logic                    app_en,
   output logic                    app_rdy,
   input  logic [DATA_WIDTH-1:0]   app_wdf_data,
   input  logic [DATA_WIDTH/8-1:0] app_wdf_mask,
   input  logic                    app_wdf_wren,
   input  logic                    app_wdf_end,
   output logic                    app_wdf_rdy,
   output logic [DATA_WIDTH-1:0]   app_rd_data,
   output logic                    app_rd_data_valid,
   output logic                    app_rd_data_end,
   output logic                    init_calib_complete
);

   localparam int unsigned MASK_W = DATA_WIDTH/8;
   localparam int unsigned WD_W   = DATA_WIDTH + MASK_W;
   localparam int unsigned CRD_W  = $clog2(RQ_DEPTH) + 1;
   localparam int unsigned CAL_W  = $clog2(CALIB_CYCLES + 1);

   logic [CAL_W-1:0]      cal_cnt;
   logic [CRD_W-1:0]      rd_credit;
   logic                  cmd_thr_c;
   logic                  wdf_thr_c;
   logic [MEM_AW-1:0]     cmd_idx_c;
   logic                  cmd_fire_c, wa_push_c, rq_push_c, wd_push_c;
   logic                  commit_c, rd_issue_c;
   logic [MEM_AW-1:0]     wa_dout, rq_dout;
   logic [WD_W-1:0]       wd_dout;
   logic                  wa_full, wa_empty, wd_full, wd_empty, rq_full, rq_empty;
   logic [DATA_WIDTH-1:0] mem [2**MEM_AW];
   logic [RD_LATENCY-1:0] vld_pipe;
   logic [DATA_WIDTH-1:0] data_pipe [RD_LATENCY];
   logic                  unused_ok;

   // Calibration counter; init_calib_complete is sticky until reset
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cal_cnt             <= '0;
         init_calib_complete <= 1'b0;
      end else if (!init_calib_complete) begin
         if (cal_cnt == CAL_W'(CALIB_CYCLES - 1)) init_calib_complete <= 1'b1;
         cal_cnt <= cal_cnt + 1'b1;
      end
   end

`ifdef DDR_MODEL_RAND_RDY_EN
   localparam logic [8:0] THRESH = 9'(RDY_THRESH);
   logic [15:0] lfsr;

   // x^16+x^14+x^13+x^11+1 Fibonacci LFSR, one step per cycle
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) lfsr <= LFSR_SEED;
      else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign cmd_thr_c = ({1'b0, lfsr[7:0]}  < THRESH);
   assign wdf_thr_c = ({1'b0, lfsr[15:8]} < THRESH);
`else
   assign cmd_thr_c = 1'b1;
   assign wdf_thr_c = 1'b1;
`endif

   // Ready from registered state only, so a same-cycle pop never reopens it
   assign app_rdy     = init_calib_complete & ~wa_full & (rd_credit != '0) & cmd_thr_c;
   assign app_wdf_rdy = init_calib_complete & ~wd_full & wdf_thr_c;

   assign cmd_idx_c  = app_addr[ADDR_LSB +: MEM_AW];
   assign cmd_fire_c = app_en & app_rdy;
   assign wa_push_c  = cmd_fire_c & (app_cmd == CMD_WR);
   assign rq_push_c  = cmd_fire_c & (app_cmd == CMD_RD);
   assign wd_push_c  = app_wdf_wren & app_wdf_rdy;
   assign commit_c   = ~wa_empty & ~wd_empty;
   // Reads wait for every earlier write to commit
   assign rd_issue_c = ~rq_empty & wa_empty;

   ddr_model_fifo #(.WIDTH(MEM_AW), .DEPTH(WQ_DEPTH)) u_wa_fifo (
      .clock(clock), .rst_n(rst_n),
      .push(wa_push_c), .din(cmd_idx_c), .pop(commit_c), .dout(wa_dout),
      .full(wa_full), .empty(wa_empty)
   );

   ddr_model_fifo #(.WIDTH(WD_W), .DEPTH(WQ_DEPTH)) u_wd_fifo (
      .clock(clock), .rst_n(rst_n),
      .push(wd_push_c), .din({app_wdf_data, app_wdf_mask}), .pop(commit_c), .dout(wd_dout),
      .full(wd_full), .empty(wd_empty)
   );

   ddr_model_fifo #(.WIDTH(MEM_AW), .DEPTH(RQ_DEPTH)) u_rq_fifo (
      .clock(clock), .rst_n(rst_n),
      .push(rq_push_c), .din(cmd_idx_c), .pop(rd_issue_c), .dout(rq_dout),
      .full(rq_full), .empty(rq_empty)
   );

   // Credits cover queued plus in-flight reads; returned with each valid beat
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         rd_credit <= CRD_W'(RQ_DEPTH);
      end else begin
         case ({rq_push_c, app_rd_data_valid})
            2'b10:   rd_credit <= rd_credit - 1'b1;
            2'b01:   rd_credit <= rd_credit + 1'b1;
            default: ;
         endcase
      end
   end

   // Byte-masked write commit; array contents survive reset
   always_ff @(posedge clock) begin
      if (commit_c) begin
         for (int unsigned b = 0; b < MASK_W; b++) begin
            if (!wd_dout[b]) mem[wa_dout][b*8 +: 8] <= wd_dout[MASK_W + b*8 +: 8];
         end
      end
   end

   // Fixed-latency read pipeline; stage 0 holds the array read
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         for (int unsigned i = 0; i < RD_LATENCY; i++) data_pipe[i] <= '0;
      end else begin
         vld_pipe[0] <= rd_issue_c;
         if (rd_issue_c) data_pipe[0] <= mem[rq_dout];
         for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            vld_pipe[i]  <= vld_pipe[i-1];
            data_pipe[i] <= data_pipe[i-1];
         end
      end
   end

   assign app_rd_data       = data_pipe[RD_LATENCY-1];
   assign app_rd_data_valid = vld_pipe[RD_LATENCY-1];
   assign app_rd_data_end   = vld_pipe[RD_LATENCY-1];

   // Inputs and configuration that carry no function in this model
   assign unused_ok = ^{app_wdf_end, app_addr, rq_full, LFSR_SEED, 32'(RDY_THRESH)};

endmodule
